// File: rtl/run_length_detector.sv
// Multi-channel consecutive-value detector: flags a lane once RUN_LEN valid samples in a row equal MATCH_VAL.
// Latency: det is 1 cycle after the completing sample (Moore), or the same cycle (MEALY=1); det_rise/hit_count are 1 cycle.
// Backpressure: none; samples are taken whenever in_valid is high, and non-valid cycles hold all state.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   clear      synchronous clear of all lane state and hit_count (beats in_valid/in)
//   in_valid   sample strobe; in[] is only looked at while high
//   in         one sample bit per lane
//   det        per-lane detect level
//   det_rise   registered one-cycle pulse when a lane enters DETECTED
//   hit_count  saturating total of detections across all lanes
module run_length_detector #(
  parameter int CHANNELS  = 4,
  parameter int RUN_LEN   = 3,
  parameter int MATCH_VAL = 1,
  parameter int MEALY     = 0,
  parameter int HIT_W     = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                in_valid,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] det,
  output logic [CHANNELS-1:0] det_rise,
  output logic [HIT_W-1:0]    hit_count
);

  // Run counter holds 0..RUN_LEN; a 1-bit counter is enough when RUN_LEN is 1.
  localparam int CNT_W = (RUN_LEN < 2) ? 1 : $clog2(RUN_LEN + 1);
  // Wide enough to add every lane's entry to a full counter without wrapping.
  localparam int SUM_W = HIT_W + $clog2(CHANNELS + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(RUN_LEN - 1);
  localparam logic             MATCH_BIT = (MATCH_VAL != 0);
  localparam logic             MEALY_EN  = (MEALY != 0);
  localparam logic [SUM_W-1:0] HIT_SAT   = SUM_W'({HIT_W{1'b1}});

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    DETECTED = 2'd2
  } lane_state_t;

  logic [CNT_W-1:0] cnt_q [CHANNELS];
  logic [CNT_W-1:0] cnt_d [CHANNELS];
  lane_state_t      state [CHANNELS];

  logic [CHANNELS-1:0] match;
  logic [CHANNELS-1:0] detected;
  logic [CHANNELS-1:0] enter;

  logic [SUM_W-1:0] n_enter;
  logic [SUM_W-1:0] hit_sum;
  logic [HIT_W-1:0] hit_d;

  // ------------------------------------------------------------------
  // State register: per-lane run counters plus the registered outputs.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      det_rise  <= '0;
      hit_count <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      det_rise  <= enter;
      hit_count <= hit_d;
    end
  end

  // ------------------------------------------------------------------
  // State decode: the lane state is a pure function of its run counter.
  // ------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state[i]    = IDLE;
      match[i]    = (in[i] == MATCH_BIT);
      if (cnt_q[i] == CNT_MAX) begin
        state[i] = DETECTED;
      end else if (cnt_q[i] != '0) begin
        state[i] = COUNTING;
      end
      detected[i] = (state[i] == DETECTED);
    end
  end

  // ------------------------------------------------------------------
  // Next state: count matching valid samples, saturating at RUN_LEN.
  // A mismatch from any state drops straight back to IDLE; invalid
  // cycles hold, so gaps in the sample stream do not break a run.
  // ------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      enter[i] = 1'b0;
      if (clear) begin
        cnt_d[i] = '0;
      end else if (in_valid) begin
        if (!match[i]) begin
          cnt_d[i] = '0;
        end else if (!detected[i]) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      // Only the RUN_LEN-1 -> RUN_LEN step counts as an entry, so a run that
      // continues past RUN_LEN neither re-pulses nor re-counts.
      enter[i] = !detected[i] && (cnt_d[i] == CNT_MAX);
    end
  end

  // ------------------------------------------------------------------
  // Shared detection counter: add this edge's entries, clamp at all-ones.
  // ------------------------------------------------------------------
  always_comb begin
    n_enter = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      n_enter = n_enter + SUM_W'(enter[i]);
    end
    hit_sum = SUM_W'(hit_count) + n_enter;
    if (clear) begin
      hit_d = '0;
    end else if (hit_sum > HIT_SAT) begin
      hit_d = HIT_SAT[HIT_W-1:0];
    end else begin
      hit_d = hit_sum[HIT_W-1:0];
    end
  end

  // ------------------------------------------------------------------
  // Output decode. In Mealy mode the completing sample raises det in its
  // own cycle; clear suppresses that look-ahead because it wins the edge.
  // ------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      det[i] = detected[i];
      if (MEALY_EN && in_valid && !clear && match[i] && (cnt_q[i] == CNT_PRE)) begin
        det[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_run_length_detector.sv
module tb_run_length_detector;

  localparam int NI = 5;
  // Instance configurations: 0 Moore, 1 Mealy, 2 narrow counter, 3 RUN_LEN=1, 4 MATCH_VAL=0 Mealy
  localparam int CFG_RL    [NI] = '{3, 3, 3, 1, 2};
  localparam int CFG_MV    [NI] = '{1, 1, 1, 1, 0};
  localparam int CFG_MEALY [NI] = '{0, 1, 0, 0, 1};
  localparam int CFG_HMAX  [NI] = '{255, 255, 7, 255, 255};

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic       in_valid;
  logic [3:0] in_bits;

  logic [3:0] det0, det1, det2, det3, det4;
  logic [3:0] rise0, rise1, rise2, rise3, rise4;
  logic [7:0] hit0, hit1, hit3, hit4;
  logic [2:0] hit_sat;

  logic [3:0] det_a  [NI];
  logic [3:0] rise_a [NI];
  logic [7:0] hit_a  [NI];

  assign det_a[0] = det0;  assign det_a[1] = det1;  assign det_a[2] = det2;
  assign det_a[3] = det3;  assign det_a[4] = det4;
  assign rise_a[0] = rise0; assign rise_a[1] = rise1; assign rise_a[2] = rise2;
  assign rise_a[3] = rise3; assign rise_a[4] = rise4;
  assign hit_a[0] = hit0;  assign hit_a[1] = hit1;  assign hit_a[2] = {5'b0, hit_sat};
  assign hit_a[3] = hit3;  assign hit_a[4] = hit4;

  run_length_detector #(.CHANNELS(4), .RUN_LEN(3), .MATCH_VAL(1), .MEALY(0), .HIT_W(8)) u_moore (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in(in_bits),
    .det(det0), .det_rise(rise0), .hit_count(hit0));
  run_length_detector #(.CHANNELS(4), .RUN_LEN(3), .MATCH_VAL(1), .MEALY(1), .HIT_W(8)) u_mealy (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in(in_bits),
    .det(det1), .det_rise(rise1), .hit_count(hit1));
  run_length_detector #(.CHANNELS(4), .RUN_LEN(3), .MATCH_VAL(1), .MEALY(0), .HIT_W(3)) u_sat (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in(in_bits),
    .det(det2), .det_rise(rise2), .hit_count(hit_sat));
  run_length_detector #(.CHANNELS(4), .RUN_LEN(1), .MATCH_VAL(1), .MEALY(0), .HIT_W(8)) u_rl1 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in(in_bits),
    .det(det3), .det_rise(rise3), .hit_count(hit3));
  run_length_detector #(.CHANNELS(4), .RUN_LEN(2), .MATCH_VAL(0), .MEALY(1), .HIT_W(8)) u_mv0 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in(in_bits),
    .det(det4), .det_rise(rise4), .hit_count(hit4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_pass;

  // Reference model: length of the current run of matching valid samples per lane
  // (unbounded), detections so far, and which lanes crossed the threshold last edge.
  int         run  [NI][4];
  int         hits [NI];
  logic [3:0] m_rise [NI];

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int c = 0; c < 4; c++) run[k][c] = 0;
      hits[k]   = 0;
      m_rise[k] = 4'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      if (clear) begin
        for (int c = 0; c < 4; c++) run[k][c] = 0;
        hits[k]   = 0;
        m_rise[k] = 4'b0;
      end else if (in_valid) begin
        int n = 0;
        m_rise[k] = 4'b0;
        for (int c = 0; c < 4; c++) begin
          int prev = run[k][c];
          run[k][c] = (int'(in_bits[c]) == CFG_MV[k]) ? prev + 1 : 0;
          if (prev < CFG_RL[k] && run[k][c] >= CFG_RL[k]) begin
            m_rise[k][c] = 1'b1;
            n++;
          end
        end
        hits[k] = (hits[k] + n > CFG_HMAX[k]) ? CFG_HMAX[k] : hits[k] + n;
      end else begin
        m_rise[k] = 4'b0;
      end
    end
  endtask

  // Expected det given the model state and the inputs currently being driven.
  function automatic logic [3:0] exp_det(int k);
    logic [3:0] d;
    for (int c = 0; c < 4; c++) begin
      d[c] = (run[k][c] >= CFG_RL[k]);
      if (CFG_MEALY[k] != 0 && in_valid && !clear &&
          int'(in_bits[c]) == CFG_MV[k] && run[k][c] == CFG_RL[k] - 1)
        d[c] = 1'b1;
    end
    return d;
  endfunction

  task automatic drive(input logic v, input logic c, input logic [3:0] d);
    @(negedge clk);
    in_valid = v;
    clear    = c;
    in_bits  = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input logic v, input logic c, input logic [3:0] d);
    drive(v, c, d);
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_bits = 4'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      n_checks += 3;
      if (det_a[k] !== 4'b0) $display("FAIL reset_det k=%0d got=%b exp=0000", k, det_a[k]); else n_pass++;
      if (rise_a[k] !== 4'b0) $display("FAIL reset_rise k=%0d got=%b exp=0000", k, rise_a[k]); else n_pass++;
      if (hit_a[k] !== 8'd0) $display("FAIL reset_hit k=%0d got=%0d exp=0", k, hit_a[k]); else n_pass++;
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_moore_basic();
    step(1'b0, 1'b1, 4'b0000);
    step(1'b1, 1'b0, 4'b0001);
    step(1'b1, 1'b0, 4'b0001);
    n_checks++;
    if (det_a[0][0] !== 1'b0) $display("FAIL t1_det_early got=%b exp=0", det_a[0][0]); else n_pass++;
    drive(1'b1, 1'b0, 4'b0001);
    n_checks++;
    if (det_a[0][0] !== 1'b0) $display("FAIL t1_moore_same_cycle got=%b exp=0", det_a[0][0]); else n_pass++;
    tick();
    n_checks += 3;
    if (det_a[0][0] !== 1'b1) $display("FAIL t1_det got=%b exp=1", det_a[0][0]); else n_pass++;
    if (rise_a[0][0] !== 1'b1) $display("FAIL t1_rise got=%b exp=1", rise_a[0][0]); else n_pass++;
    if (hit_a[0] !== 8'd1) $display("FAIL t1_hit got=%0d exp=1", hit_a[0]); else n_pass++;
    step(1'b1, 1'b0, 4'b0001);
    n_checks += 3;
    if (det_a[0][0] !== 1'b1) $display("FAIL t1_det_hold got=%b exp=1", det_a[0][0]); else n_pass++;
    if (rise_a[0][0] !== 1'b0) $display("FAIL t1_rise_once got=%b exp=0", rise_a[0][0]); else n_pass++;
    if (hit_a[0] !== 8'd1) $display("FAIL t1_hit_once got=%0d exp=1", hit_a[0]); else n_pass++;
  endtask

  task automatic test_run_broken();
    logic seq [5];
    seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    step(1'b0, 1'b1, 4'b0000);
    for (int s = 0; s < 5; s++) begin
      step(1'b1, 1'b0, {2'b00, seq[s], 1'b0});
      n_checks += 2;
      if (det_a[0][1] !== 1'b0) $display("FAIL t2_det s=%0d got=%b exp=0", s, det_a[0][1]); else n_pass++;
      if (hit_a[0] !== 8'd0) $display("FAIL t2_hit s=%0d got=%0d exp=0", s, hit_a[0]); else n_pass++;
    end
    step(1'b1, 1'b0, 4'b0010);
    n_checks += 2;
    if (det_a[0][1] !== 1'b1) $display("FAIL t2_det_final got=%b exp=1", det_a[0][1]); else n_pass++;
    if (hit_a[0] !== 8'd1) $display("FAIL t2_hit_final got=%0d exp=1", hit_a[0]); else n_pass++;
  endtask

  task automatic test_gaps();
    step(1'b0, 1'b1, 4'b0000);
    step(1'b1, 1'b0, 4'b0100);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'b0, 4'b0100);
      n_checks += 2;
      if (rise_a[0] !== 4'b0) $display("FAIL t3_gap_rise g=%0d got=%b exp=0000", g, rise_a[0]); else n_pass++;
      if (det_a[0][2] !== 1'b0) $display("FAIL t3_gap_det g=%0d got=%b exp=0", g, det_a[0][2]); else n_pass++;
    end
    step(1'b1, 1'b0, 4'b0100);
    n_checks++;
    if (det_a[0][2] !== 1'b0) $display("FAIL t3_det_early got=%b exp=0", det_a[0][2]); else n_pass++;
    step(1'b1, 1'b0, 4'b0100);
    n_checks += 2;
    if (det_a[0][2] !== 1'b1) $display("FAIL t3_det got=%b exp=1", det_a[0][2]); else n_pass++;
    if (rise_a[0][2] !== 1'b1) $display("FAIL t3_rise got=%b exp=1", rise_a[0][2]); else n_pass++;
  endtask

  task automatic test_mealy();
    step(1'b0, 1'b1, 4'b0000);
    step(1'b1, 1'b0, 4'b1000);
    step(1'b1, 1'b0, 4'b1000);
    drive(1'b1, 1'b0, 4'b1000);
    n_checks += 2;
    if (det_a[1][3] !== 1'b1) $display("FAIL t4_mealy_same_cycle got=%b exp=1", det_a[1][3]); else n_pass++;
    if (det_a[0][3] !== 1'b0) $display("FAIL t4_moore_same_cycle got=%b exp=0", det_a[0][3]); else n_pass++;
    tick();
    n_checks += 2;
    if (det_a[1][3] !== 1'b1) $display("FAIL t4_mealy_held got=%b exp=1", det_a[1][3]); else n_pass++;
    if (rise_a[1][3] !== 1'b1) $display("FAIL t4_mealy_rise got=%b exp=1", rise_a[1][3]); else n_pass++;
    step(1'b1, 1'b0, 4'b0000);
    n_checks++;
    if (det_a[1][3] !== 1'b0) $display("FAIL t4_mealy_drop got=%b exp=0", det_a[1][3]); else n_pass++;
  endtask

  task automatic test_saturation();
    step(1'b0, 1'b1, 4'b0000);
    repeat (3) step(1'b1, 1'b0, 4'b1111);
    n_checks += 3;
    if (hit_a[0] !== 8'd4) $display("FAIL t5_hit4 got=%0d exp=4", hit_a[0]); else n_pass++;
    if (hit_a[2] !== 8'd4) $display("FAIL t5_sat_hit4 got=%0d exp=4", hit_a[2]); else n_pass++;
    if (det_a[0] !== 4'b1111) $display("FAIL t5_det_all got=%b exp=1111", det_a[0]); else n_pass++;
    step(1'b1, 1'b0, 4'b0000);
    repeat (3) step(1'b1, 1'b0, 4'b0011);
    n_checks++;
    if (hit_a[2] !== 8'd6) $display("FAIL t5_sat_hit6 got=%0d exp=6", hit_a[2]); else n_pass++;
    step(1'b1, 1'b0, 4'b0000);
    repeat (3) step(1'b1, 1'b0, 4'b1111);
    n_checks += 2;
    if (hit_a[2] !== 8'd7) $display("FAIL t5_sat_clamp got=%0d exp=7", hit_a[2]); else n_pass++;
    if (hit_a[0] !== 8'd10) $display("FAIL t5_hit10 got=%0d exp=10", hit_a[0]); else n_pass++;
    step(1'b0, 1'b1, 4'b1111);
    n_checks += 3;
    if (hit_a[2] !== 8'd0) $display("FAIL t5_clear_hit got=%0d exp=0", hit_a[2]); else n_pass++;
    if (det_a[0] !== 4'b0) $display("FAIL t5_clear_det got=%b exp=0000", det_a[0]); else n_pass++;
    if (hit_a[0] !== 8'd0) $display("FAIL t5_clear_hit_m got=%0d exp=0", hit_a[0]); else n_pass++;
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b1, 4'b0000);
    repeat (3) step(1'b1, 1'b0, 4'b0010);
    repeat (2) step(1'b1, 1'b0, 4'b0011);
    n_checks++;
    if (det_a[0] !== 4'b0010) $display("FAIL t6_pre got=%b exp=0010", det_a[0]); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < NI; k++) begin
      n_checks += 3;
      if (det_a[k] !== 4'b0) $display("FAIL t6_arst_det k=%0d got=%b exp=0000", k, det_a[k]); else n_pass++;
      if (rise_a[k] !== 4'b0) $display("FAIL t6_arst_rise k=%0d got=%b exp=0000", k, rise_a[k]); else n_pass++;
      if (hit_a[k] !== 8'd0) $display("FAIL t6_arst_hit k=%0d got=%0d exp=0", k, hit_a[k]); else n_pass++;
    end
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    step(1'b1, 1'b0, 4'b0001);
    n_checks += 3;
    if (det_a[0][0] !== 1'b0) $display("FAIL t6_rerun1 got=%b exp=0", det_a[0][0]); else n_pass++;
    if (det_a[3][0] !== 1'b1) $display("FAIL t6_rl1_det got=%b exp=1", det_a[3][0]); else n_pass++;
    if (rise_a[3] !== 4'b0001) $display("FAIL t6_rl1_rise got=%b exp=0001", rise_a[3]); else n_pass++;
    drive(1'b1, 1'b0, 4'b0001);
    n_checks++;
    if (det_a[4] !== 4'b1110) $display("FAIL t6_mv0_mealy got=%b exp=1110", det_a[4]); else n_pass++;
    tick();
    n_checks += 2;
    if (det_a[0][0] !== 1'b0) $display("FAIL t6_rerun2 got=%b exp=0", det_a[0][0]); else n_pass++;
    if (hit_a[4] !== 8'd3) $display("FAIL t6_mv0_hit got=%0d exp=3", hit_a[4]); else n_pass++;
    step(1'b1, 1'b0, 4'b0001);
    n_checks++;
    if (det_a[0][0] !== 1'b1) $display("FAIL t6_rerun3 got=%b exp=1", det_a[0][0]); else n_pass++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      logic v, c;
      logic [3:0] d;
      v = ($urandom_range(3) != 0);
      c = ($urandom_range(39) == 0);
      d = 4'($urandom);
      if ($urandom_range(1) == 1) d = d | 4'($urandom);
      drive(v, c, d);
      for (int k = 0; k < NI; k++) begin
        n_checks++;
        if (det_a[k] !== exp_det(k))
          $display("FAIL rnd_det_pre n=%0d k=%0d got=%b exp=%b", n, k, det_a[k], exp_det(k));
        else n_pass++;
      end
      tick();
      for (int k = 0; k < NI; k++) begin
        n_checks += 3;
        if (det_a[k] !== exp_det(k))
          $display("FAIL rnd_det n=%0d k=%0d got=%b exp=%b", n, k, det_a[k], exp_det(k));
        else n_pass++;
        if (rise_a[k] !== m_rise[k])
          $display("FAIL rnd_rise n=%0d k=%0d got=%b exp=%b", n, k, rise_a[k], m_rise[k]);
        else n_pass++;
        if (int'(hit_a[k]) != hits[k])
          $display("FAIL rnd_hit n=%0d k=%0d got=%0d exp=%0d", n, k, hit_a[k], hits[k]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_moore_basic();
    test_run_broken();
    test_gaps();
    test_mealy();
    test_saturation();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
